rmw_unit: RTL and testbench
===========================

RMW_UNIT -- requirements
Module: rmw_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the memory data width in bits (legal values 8 or 16).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the memory address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 3 bits: operation code, captured with start.
REQ-007 The block SHALL have port ea, input, ADDR_W bits: effective address, captured with start.
REQ-008 The block SHALL have port carry_in, input, 1 bit: carry for ROL/ROR, captured with start.
REQ-009 The block SHALL have port idata, input, DATA_W bits: memory read data.
REQ-010 The block SHALL have port addr, output, ADDR_W bits: memory address.
REQ-011 The block SHALL have port odata, output, DATA_W bits: memory write data.
REQ-012 The block SHALL have port rw, output, 1 bit: 1 = read or idle, 0 = write.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port flags, output, 3 bits: {N,Z,C} of the last completed operation.

Function
REQ-016 The states SHALL be IDLE, READ, DUMMY, WRITE and FIN; DUMMY is present only when the configuration macro is defined.
REQ-017 IDLE with start=1 SHALL latch op, ea and carry_in and go to READ; start in any other state SHALL be ignored and not queued.
REQ-018 READ SHALL drive addr=ea and rw=1, capture idata into an operand register at the cycle end, and then go to DUMMY (macro defined) or WRITE.
REQ-019 DUMMY SHALL drive addr=ea, rw=0 and odata=the unmodified operand, then go to WRITE.
REQ-020 WRITE SHALL drive addr=ea, rw=0 and odata=the result, update flags at the cycle end, then go to FIN.
REQ-021 FIN SHALL assert done=1 and rw=1, then go to IDLE; start is not accepted in FIN.
REQ-022 Latency from start sampled to done high SHALL be 4 cycles with the macro defined and 3 cycles without.
REQ-023 Op codes SHALL be:
- 000 INC: result = operand+1, mod 2^DATA_W.
- 001 DEC: result = operand-1, mod 2^DATA_W.
- 010 ASL: C = MSB, result = operand shifted left with LSB=0.
- 011 LSR: C = LSB, result = operand shifted right with MSB=0.
- 100 ROL: as ASL but LSB = carry_in.
- 101 ROR: as LSR but MSB = carry_in.
- 110 and 111 PASS: result = operand.
REQ-024 N SHALL equal result[DATA_W-1], and Z SHALL be 1 exactly when the result is all zeros.
REQ-025 C SHALL hold its previous value for INC, DEC and PASS.
REQ-026 In IDLE, addr SHALL hold the last ea, odata SHALL hold the last driven value, rw=1 and done=0.
REQ-027 Wrap-around: INC of all-ones SHALL give 0 with Z=1; DEC of 0 SHALL give all-ones with N=1.

Reset
REQ-028 While reset=1 at a clock edge, the next state SHALL be IDLE and the following SHALL be 0: busy, done, flags, addr, odata, operand register and latched op.
REQ-029 rw SHALL be 1 in the cycle after reset is sampled.
REQ-030 Reset SHALL override start and any in-flight operation, including mid-DUMMY and mid-WRITE; done is never pulsed for an aborted operation and flags stay 0.

Configuration
REQ-031 Macro RMW_DUMMY_WRITE_EN defined SHALL include the DUMMY state (6502-style write-back of the original value, 4-cycle latency).
REQ-032 Macro RMW_DUMMY_WRITE_EN undefined SHALL remove the DUMMY state and its logic, giving 3-cycle latency with exactly one rw=0 cycle per operation.

Verification
REQ-033 DEC, ea=16'h0080, idata=8'h01 -> WRITE drives addr=16'h0080, odata=8'h00, rw=0; then flags=3'b010 and done pulses.
REQ-034 DEC, ea=16'h0081, idata=8'h00 -> odata=8'hFF, then flags=3'b100.
REQ-035 ROR, carry_in=1, idata=8'h01 -> odata=8'h80, then flags=3'b101; with the macro defined, the DUMMY cycle shows odata=8'h01, rw=0.
REQ-036 DATA_W=16, INC, idata=16'hFFFF -> odata=16'h0000, Z=1, C unchanged from the prior operation.
REQ-037 start held high throughout one operation -> exactly one operation, and the next begins only from IDLE after FIN.
REQ-038 reset asserted during WRITE -> next cycle rw=1, busy=0, done=0, flags=0, and no further write cycles.

Source files
------------

// File: rtl/rmw_unit.sv
// Read-modify-write sequencer: reads one memory word, applies INC/DEC/shift/rotate, writes it back.
// Define RMW_DUMMY_WRITE_EN to add the 6502-style write-back of the original value (4-cycle latency).
module rmw_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] ea,
    input  logic              carry_in,
    input  logic [DATA_W-1:0] idata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] odata,
    output logic              rw,
    output logic              busy,
    output logic              done,
    output logic [2:0]        flags
);

`ifdef RMW_DUMMY_WRITE_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DUMMY, S_WRITE, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_FIN} state_t;
`endif

    state_t            state_q;
    logic [2:0]        op_q;
    logic              carry_q;
    logic [DATA_W-1:0] operand_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] odata_q;
    logic              rw_q;
    logic              busy_q;
    logic              done_q;
    logic [2:0]        flags_q;

    function automatic logic [DATA_W-1:0] alu_res(input logic [2:0] o,
                                                  input logic [DATA_W-1:0] v,
                                                  input logic cin);
        logic [DATA_W-1:0] r;
        case (o)
            3'b000:  r = v + DATA_W'(1);
            3'b001:  r = v - DATA_W'(1);
            3'b010:  r = {v[DATA_W-2:0], 1'b0};
            3'b011:  r = {1'b0, v[DATA_W-1:1]};
            3'b100:  r = {v[DATA_W-2:0], cin};
            3'b101:  r = {cin, v[DATA_W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // INC, DEC and PASS leave C untouched
    function automatic logic alu_c(input logic [2:0] o,
                                   input logic [DATA_W-1:0] v,
                                   input logic cprev);
        logic c;
        case (o)
            3'b010, 3'b100: c = v[DATA_W-1];
            3'b011, 3'b101: c = v[0];
            default:        c = cprev;
        endcase
        return c;
    endfunction

    logic [DATA_W-1:0] res_w;
    logic              c_w;
    assign res_w = alu_res(op_q, operand_q, carry_q);
    assign c_w   = alu_c(op_q, operand_q, flags_q[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            carry_q   <= 1'b0;
            operand_q <= '0;
            addr_q    <= '0;
            odata_q   <= '0;
            rw_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flags_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_READ;
                        op_q    <= op;
                        carry_q <= carry_in;
                        addr_q  <= ea;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    operand_q <= idata;
                    rw_q      <= 1'b0;
`ifdef RMW_DUMMY_WRITE_EN
                    state_q   <= S_DUMMY;
                    odata_q   <= idata;
`else
                    // result computed straight from the read data so WRITE follows READ
                    state_q   <= S_WRITE;
                    odata_q   <= alu_res(op_q, idata, carry_q);
`endif
                end
`ifdef RMW_DUMMY_WRITE_EN
                S_DUMMY: begin
                    state_q <= S_WRITE;
                    odata_q <= res_w;
                end
`endif
                S_WRITE: begin
                    state_q <= S_FIN;
                    flags_q <= {res_w[DATA_W-1], (res_w == '0), c_w};
                    rw_q    <= 1'b1;
                    done_q  <= 1'b1;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    rw_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr  = addr_q;
    assign odata = odata_q;
    assign rw    = rw_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_rmw_unit.sv
// Randomized bench for rmw_unit: 8-bit and 16-bit instances share control, checked against an arithmetic model.
module tb_rmw_unit;

`ifdef RMW_DUMMY_WRITE_EN
    localparam int WCYC = 3;
`else
    localparam int WCYC = 2;
`endif
    localparam int DCYC = WCYC + 1;

    logic        clk = 1'b0;
    logic        reset, start, cin;
    logic [2:0]  op;
    logic [15:0] ea;
    logic [7:0]  id8;
    logic [15:0] id16;

    logic [15:0] a8, a16;
    logic [7:0]  od8;
    logic [15:0] od16;
    logic        rw8, rw16, busy8, busy16, done8, done16;
    logic [2:0]  fl8, fl16;

    logic [2:0]  m8, m16;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rmw_unit #(.DATA_W(8), .ADDR_W(16)) u8 (
        .clk(clk), .reset(reset), .start(start), .op(op), .ea(ea), .carry_in(cin),
        .idata(id8), .addr(a8), .odata(od8), .rw(rw8), .busy(busy8), .done(done8), .flags(fl8));

    rmw_unit #(.DATA_W(16), .ADDR_W(16)) u16 (
        .clk(clk), .reset(reset), .start(start), .op(op), .ea(ea), .carry_in(cin),
        .idata(id16), .addr(a16), .odata(od16), .rw(rw16), .busy(busy16), .done(done16), .flags(fl16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: width w, op o, operand v, carry in ci, previous flags -> result and new flags
    task automatic ref_op(input int w, input int o, input int v, input int ci,
                          input logic [2:0] fprev, output int res, output logic [2:0] fnew);
        int m, c;
        m = 1 << w;
        c = int'(fprev[0]);
        case (o)
            0: res = (v + 1) % m;
            1: res = (v + m - 1) % m;
            2: begin c = v / (m / 2); res = (v * 2) % m; end
            3: begin c = v % 2; res = v / 2; end
            4: begin c = v / (m / 2); res = (v * 2) % m + ci; end
            5: begin c = v % 2; res = v / 2 + ci * (m / 2); end
            default: res = v;
        endcase
        fnew = {res >= m / 2, res == 0, c != 0};
    endtask

    task automatic run_op(input int o, input int e, input int ci, input int v8, input int v16,
                          input bit hold);
        int r8, r16, wr, dn;
        logic [2:0] f8, f16;
        ref_op(8, o, v8, ci, m8, r8, f8);
        ref_op(16, o, v16, ci, m16, r16, f16);
        wr = 0;
        dn = 0;
        @(negedge clk);
        op = 3'(o); ea = 16'(e); cin = 1'(ci); id8 = 8'(v8); id16 = 16'(v16); start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("read_addr", a8, 32'(e));
        chk("read_rw", rw8, 1);
        chk("read_busy", {busy16, busy8}, 2'b11);
        for (int cyc = 2; cyc <= DCYC; cyc++) begin
            @(negedge clk);
            if (!rw8) wr++;
            if (done8) dn++;
`ifdef RMW_DUMMY_WRITE_EN
            if (cyc == 2) begin
                chk("dummy_od8", od8, 32'(v8));
                chk("dummy_od16", od16, 32'(v16));
                chk("dummy_rw", rw8, 0);
            end
`endif
            if (cyc == WCYC) begin
                chk("wr_addr", a16, 32'(e));
                chk("wr_od8", od8, 32'(r8));
                chk("wr_od16", od16, 32'(r16));
                chk("wr_rw", {rw16, rw8}, 0);
                chk("wr_done", done8, 0);
            end
            if (cyc == DCYC) begin
                m8 = f8;
                m16 = f16;
                chk("fin_done", {done16, done8}, 2'b11);
                chk("fin_rw", rw8, 1);
                chk("fin_fl8", fl8, 32'(m8));
                chk("fin_fl16", fl16, 32'(m16));
            end
        end
        chk("writes_per_op", wr, WCYC - 1);
        chk("done_pulses", dn, 1);
        @(negedge clk);
        chk("idle_busy", busy8, 0);
        chk("idle_done", done8, 0);
        chk("idle_rw", rw8, 1);
        chk("idle_addr", a8, 32'(e));
        chk("idle_od8", od8, 32'(r8));
    endtask

    initial begin
        int r8, r16;
        logic [2:0] f8, f16;
        reset = 1'b1; start = 1'b0; op = '0; ea = '0; cin = 1'b0; id8 = '0; id16 = '0;
        m8 = '0; m16 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_flags", fl8, 0);
        chk("rst_addr", a8, 0);
        chk("rst_odata", od16, 0);
        chk("rst_rw", rw8, 1);
        reset = 1'b0;

        // directed corner cases
        run_op(1, 'h0080, 0, 'h01, 'h0001, 0);
        chk("dec_to_zero_flags", fl8, 3'b010);
        run_op(1, 'h0081, 0, 'h00, 'h0000, 0);
        chk("dec_wrap_flags", fl8, 3'b100);
        run_op(5, 'h0082, 1, 'h01, 'h0001, 0);
        chk("ror_flags", fl8, 3'b101);
        run_op(2, 'h0083, 0, 'h80, 'h8000, 0);
        run_op(0, 'h0084, 0, 'hFF, 'hFFFF, 0);
        chk("inc16_wrap_flags", fl16, 3'b011);

        // start held high: FIN must not accept it, IDLE then starts exactly one more op
        run_op(0, 'h1234, 0, 'h10, 'h0010, 1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", busy8, 1);
        ref_op(8, 0, 'h10, 0, m8, r8, f8);
        ref_op(16, 0, 'h10, 0, m16, r16, f16);
        m8 = f8; m16 = f16;
        repeat (DCYC - 1) @(negedge clk);
        chk("hold_done", done8, 1);
        chk("hold_od8", od8, 32'(r8));
        @(negedge clk);
        chk("hold_idle_busy", busy8, 0);
        repeat (2) @(negedge clk);
        chk("hold_no_third", busy8, 0);

        for (int i = 0; i < 40; i++)
            run_op($urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 1),
                   $urandom_range(0, 255), $urandom_range(0, 65535), 0);

        // reset during WRITE aborts the op
        @(negedge clk);
        op = 3'd0; ea = 16'h4000; id8 = 8'h7F; id16 = 16'h7FFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (WCYC - 1) @(negedge clk);
        chk("abort_in_write", rw8, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m8 = '0; m16 = '0;
        chk("abort_rw", rw8, 1);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_flags", {fl16, fl8}, 0);
        chk("abort_odata", od8, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_quiet", {done8, rw8, busy8}, 3'b010);
        end
        run_op(3, 'h0055, 0, 'h03, 'h0003, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
